intr_ctrl: RTL

//  Multi-source interrupt controller between external requesters (keyboard, ethernet, accelerators) and the fetch stage.

---
 rtl/intr_pkg.sv | 13 +
 rtl/intr_sync.sv | 28 ++
 rtl/intr_ctrl.sv | 113 +++++++++++
 3 files changed

// File: rtl/intr_pkg.sv
// Shared types and constants for the interrupt controller slice.
package intr_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        SERVICE
    } intr_state_t;

    localparam int unsigned PRIO_FIXED = 0;
    localparam int unsigned PRIO_RR    = 1;

endpackage

// File: rtl/intr_sync.sv
// Single-source synchroniser with rising-edge detect; one instance per interrupt line.
module intr_sync
    import intr_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], level};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign rise = chain[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/intr_ctrl.sv
// Multi-source interrupt controller: pending/mask tracking, arbitration,
// single-pulse issue to fetch and nesting block until rti/rsi.
module intr_ctrl
    import intr_pkg::*;
#(
    parameter  int unsigned NUM_SRC     = 4,
    parameter  int unsigned DATA_W      = 32,
    parameter  int unsigned PRIO_MODE   = 0,
    parameter  int unsigned SYNC_STAGES = 2,
    localparam int unsigned ID_W        = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC-1:0]        irq_in,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic                      mask_we,
    input  logic [NUM_SRC-1:0]        mask_wdata,
    input  logic                      mem_busy,
    input  logic                      rti,
    input  logic                      rsi,
    output logic                      interrupt,
    output logic                      in_service,
    output logic [ID_W-1:0]           irq_id,
    output logic [DATA_W-1:0]         irq_data,
    output logic [NUM_SRC-1:0]        pending
);

    intr_state_t         state, state_n;
    logic [NUM_SRC-1:0]  mask;
    logic [NUM_SRC-1:0]  rise;
    logic [NUM_SRC-1:0]  eligible;
    logic [NUM_SRC-1:0]  clear;
    logic [ID_W-1:0]     ptr;
    logic [ID_W-1:0]     grant_id;
    logic                grant;
    logic [DATA_W-1:0]   data_arr [NUM_SRC];

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        intr_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk   (clk),
            .rst   (rst),
            .level (irq_in[i]),
            .rise  (rise[i])
        );
        assign data_arr[i] = src_data[i*DATA_W +: DATA_W];
    end

    // Fixed mode scans from index 0; round-robin scans from ptr and wraps.
    function automatic logic [ID_W-1:0] arbitrate(input logic [NUM_SRC-1:0] req,
                                                  input logic [ID_W-1:0]    start);
        logic [ID_W-1:0] sel;
        logic            found;
        int unsigned     idx;
        sel   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (PRIO_MODE == PRIO_RR) idx = (32'(start) + k) % NUM_SRC;
            else                      idx = k;
            if (!found && req[idx]) begin
                sel   = ID_W'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n  = state;
        grant    = 1'b0;
        eligible = pending & mask;
        grant_id = arbitrate(eligible, ptr);
        case (state)
            IDLE: begin
                if (|eligible && !mem_busy) begin
                    grant   = 1'b1;
                    state_n = ISSUE;
                end
            end
            ISSUE:   state_n = SERVICE;
            SERVICE: if (rti || rsi) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        clear = grant ? (NUM_SRC'(1) << grant_id) : '0;
    end

    assign interrupt  = (state == ISSUE);
    assign in_service = (state == SERVICE);

    // A fresh edge in the grant cycle re-sets the bit being cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending  <= '0;
            mask     <= '1;
            ptr      <= '0;
            irq_id   <= '0;
            irq_data <= '0;
        end else begin
            pending <= (pending & ~clear) | rise;
            if (mask_we) mask <= mask_wdata;
            if (grant) begin
                irq_id   <= grant_id;
                irq_data <= data_arr[grant_id];
                ptr      <= (grant_id == ID_W'(NUM_SRC - 1)) ? '0 : grant_id + ID_W'(1);
            end
        end
    end

endmodule
